// File: rtl/alu_op_sequencer.sv
// Command-level controller for a shared 5-bit adder/subtractor: runs ADD/SUB/CMP in one
// pass and an unsigned 5x5 MUL as five shift-add iterations, returning 10-bit results.
module alu_op_sequencer #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [4:0] cmd_a,
    input  logic [4:0] cmd_b,
    output logic [4:0] adder_a,
    output logic [4:0] adder_b,
    output logic       adder_cin,
    input  logic [4:0] adder_result,
    input  logic       adder_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_v,
    output logic       err
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [4:0] r_a;
    logic [4:0] r_q;
    logic [4:0] r_p;
    logic [2:0] r_cnt;
    logic [9:0] r_res;
    logic       r_c;
    logic       r_z;
    logic       r_v;
    logic       r_err;
    logic [9:0] w_shifted;
    logic       w_lastIter;

    // {P,Q} after one shift-add step: the adder's carry becomes the new P MSB.
    assign w_shifted  = {adder_cout, adder_result, r_q[4:1]};
    assign w_lastIter = (r_cnt == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        adder_a   = 5'd0;
        adder_b   = 5'd0;
        adder_cin = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_next = ((cmd_op == OP_MUL) && MUL_EN) ? MUL : EXEC;
                end
            end
            EXEC: begin
                if (r_op != OP_MUL) begin
                    adder_a   = r_a;
                    adder_b   = r_q;
                    adder_cin = (r_op != OP_ADD);
                end
                w_next = DONE;
            end
            MUL: begin
                adder_a = r_p;
                adder_b = r_q[0] ? r_a : 5'd0;
                if (w_lastIter) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latching, multiply iterations and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= OP_ADD;
            r_a   <= 5'd0;
            r_q   <= 5'd0;
            r_p   <= 5'd0;
            r_cnt <= 3'd0;
            r_res <= 10'd0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_v   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_a   <= cmd_a;
                        r_q   <= cmd_b;
                        r_p   <= 5'd0;
                        r_cnt <= 3'd0;
                    end
                end
                EXEC: begin
                    if (r_op == OP_MUL) begin
                        r_res <= 10'd0;
                        r_c   <= 1'b0;
                        r_z   <= 1'b0;
                        r_v   <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_res <= (r_op == OP_CMP) ? 10'd0 : {5'd0, adder_result};
                        r_c   <= adder_cout;
                        r_z   <= (adder_result == 5'd0);
                        r_err <= 1'b0;
                        if (r_op == OP_ADD) begin
                            r_v <= (r_a[4] == r_q[4]) && (adder_result[4] != r_a[4]);
                        end else begin
                            r_v <= (r_a[4] != r_q[4]) && (adder_result[4] != r_a[4]);
                        end
                    end
                end
                MUL: begin
                    r_p   <= w_shifted[9:5];
                    r_q   <= w_shifted[4:0];
                    r_cnt <= r_cnt + 3'd1;
                    if (w_lastIter) begin
                        r_res <= w_shifted;
                        r_c   <= 1'b0;
                        r_z   <= (w_shifted == 10'd0);
                        r_v   <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign res_valid = (r_state == DONE);
    assign res       = r_res;
    assign flag_c    = r_c;
    assign flag_z    = r_z;
    assign flag_v    = r_v;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one MUL-enabled instance and one MUL-disabled
// instance, each wired to a behavioural 5-bit adder/subtractor.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] cmdOp;
    logic [4:0] cmdA;
    logic [4:0] cmdB;
    logic       cmdValid0, cmdValid1;
    logic       resReady0, resReady1;
    logic       sel;

    logic       cmdReady0, cmdReady1;
    logic [4:0] adderA0, adderA1, adderB0, adderB1;
    logic       adderCin0, adderCin1;
    logic [4:0] adderRes0, adderRes1;
    logic       adderCout0, adderCout1;
    logic       resValid0, resValid1;
    logic [9:0] res0, res1;
    logic       flagC0, flagC1, flagZ0, flagZ1, flagV0, flagV1, err0, err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural adder: B is inverted when cin=1, carry-in added.
    assign {adderCout0, adderRes0} = {1'b0, adderA0} + {1'b0, (adderCin0 ? ~adderB0 : adderB0)} + {5'd0, adderCin0};
    assign {adderCout1, adderRes1} = {1'b0, adderA1} + {1'b0, (adderCin1 ? ~adderB1 : adderB1)} + {5'd0, adderCin1};

    alu_op_sequencer #(.MUL_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rstN), .cmd_valid(cmdValid0), .cmd_ready(cmdReady0),
        .cmd_op(cmdOp), .cmd_a(cmdA), .cmd_b(cmdB),
        .adder_a(adderA0), .adder_b(adderB0), .adder_cin(adderCin0),
        .adder_result(adderRes0), .adder_cout(adderCout0),
        .res_valid(resValid0), .res_ready(resReady0), .res(res0),
        .flag_c(flagC0), .flag_z(flagZ0), .flag_v(flagV0), .err(err0)
    );

    alu_op_sequencer #(.MUL_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rstN), .cmd_valid(cmdValid1), .cmd_ready(cmdReady1),
        .cmd_op(cmdOp), .cmd_a(cmdA), .cmd_b(cmdB),
        .adder_a(adderA1), .adder_b(adderB1), .adder_cin(adderCin1),
        .adder_result(adderRes1), .adder_cout(adderCout1),
        .res_valid(resValid1), .res_ready(resReady1), .res(res1),
        .flag_c(flagC1), .flag_z(flagZ1), .flag_v(flagV1), .err(err1)
    );

    wire       sCmdReady = sel ? cmdReady1 : cmdReady0;
    wire [4:0] sAdderA   = sel ? adderA1 : adderA0;
    wire [4:0] sAdderB   = sel ? adderB1 : adderB0;
    wire       sAdderCin = sel ? adderCin1 : adderCin0;
    wire       sResValid = sel ? resValid1 : resValid0;
    wire [9:0] sRes      = sel ? res1 : res0;
    wire       sFlagC    = sel ? flagC1 : flagC0;
    wire       sFlagZ    = sel ? flagZ1 : flagZ0;
    wire       sFlagV    = sel ? flagV1 : flagV0;
    wire       sErr      = sel ? err1 : err0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command on the selected instance (entered and left at a negedge) and
    // follow it until res_valid, checking adder drive every busy cycle and the latency.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input int expLat);
        int edges;
        logic legal;
        logic [4:0] mP, mQ, bSel;
        logic [5:0] sum;
        legal = !(sel && op == 2'b10);
        cmdOp = op; cmdA = a; cmdB = b;
        if (sel) cmdValid1 = 1'b1; else cmdValid0 = 1'b1;
        checkOutput("cmd_ready idle", {31'd0, sCmdReady}, 1);
        @(posedge clk);
        @(negedge clk);
        cmdValid0 = 1'b0; cmdValid1 = 1'b0;
        cmdA = 5'd0; cmdB = 5'd0;
        edges = 1;
        mP = 5'd0; mQ = b;
        while (!sResValid && edges < 20) begin
            checkOutput("cmd_ready busy", {31'd0, sCmdReady}, 0);
            if (op == 2'b10 && !sel) begin
                bSel = mQ[0] ? a : 5'd0;
                checkOutput("mul adder_a", {27'd0, sAdderA}, {27'd0, mP});
                checkOutput("mul adder_b", {27'd0, sAdderB}, {27'd0, bSel});
                checkOutput("mul adder_cin", {31'd0, sAdderCin}, 0);
                sum = {1'b0, mP} + {1'b0, bSel};
                {mP, mQ} = {sum, mQ[4:1]};
            end else begin
                checkOutput("exec adder_a", {27'd0, sAdderA}, legal ? {27'd0, a} : 0);
                checkOutput("exec adder_b", {27'd0, sAdderB}, legal ? {27'd0, b} : 0);
                checkOutput("exec adder_cin", {31'd0, sAdderCin}, (legal && op != 2'b00) ? 1 : 0);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", edges, expLat);
    endtask

    task automatic checkResult(input logic [9:0] eRes, input logic eC, input logic eZ, input logic eV, input logic eErr);
        checkOutput("res_valid", {31'd0, sResValid}, 1);
        checkOutput("res", {22'd0, sRes}, {22'd0, eRes});
        checkOutput("flag_c", {31'd0, sFlagC}, {31'd0, eC});
        checkOutput("flag_z", {31'd0, sFlagZ}, {31'd0, eZ});
        checkOutput("flag_v", {31'd0, sFlagV}, {31'd0, eV});
        checkOutput("err", {31'd0, sErr}, {31'd0, eErr});
        checkOutput("done adder_a", {27'd0, sAdderA}, 0);
    endtask

    task automatic acceptResult();
        if (sel) resReady1 = 1'b1; else resReady0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resReady0 = 1'b0; resReady1 = 1'b0;
        checkOutput("res_valid after accept", {31'd0, sResValid}, 0);
        checkOutput("cmd_ready after accept", {31'd0, sCmdReady}, 1);
    endtask

    initial begin
        rstN = 1'b0; sel = 1'b0;
        cmdValid0 = 1'b0; cmdValid1 = 1'b0; resReady0 = 1'b0; resReady1 = 1'b0;
        cmdOp = 2'b00; cmdA = 5'd0; cmdB = 5'd0;
        #2;
        checkOutput("reset res_valid", {31'd0, resValid0}, 0);
        checkOutput("reset cmd_ready", {31'd0, cmdReady0}, 1);
        checkOutput("reset res", {22'd0, res0}, 0);
        checkOutput("reset adder_b", {27'd0, adderB0}, 0);
        checkOutput("reset err", {31'd0, err0}, 0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(2'b00, 5'd13, 5'd9, 2);
        checkResult(10'd22, 1'b0, 1'b0, 1'b1, 1'b0);
        acceptResult();

        applyStimulus(2'b01, 5'd5, 5'd7, 2);
        checkResult(10'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        acceptResult();

        applyStimulus(2'b11, 5'd18, 5'd18, 2);
        checkResult(10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        acceptResult();

        applyStimulus(2'b10, 5'd31, 5'd31, 6);
        checkResult(10'd961, 1'b0, 1'b0, 1'b0, 1'b0);
        acceptResult();

        applyStimulus(2'b00, 5'd1, 5'd2, 2);
        checkResult(10'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("backpressure res", {22'd0, res0}, 3);
            checkOutput("backpressure res_valid", {31'd0, resValid0}, 1);
            checkOutput("backpressure cmd_ready", {31'd0, cmdReady0}, 0);
        end
        acceptResult();
        applyStimulus(2'b01, 5'd3, 5'd1, 2);
        checkResult(10'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        acceptResult();

        cmdOp = 2'b10; cmdA = 5'd7; cmdB = 5'd3; cmdValid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmdValid0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid-mul adder_a", {27'd0, adderA0}, 5);
        rstN = 1'b0;
        #1;
        checkOutput("async reset res_valid", {31'd0, resValid0}, 0);
        checkOutput("async reset cmd_ready", {31'd0, cmdReady0}, 1);
        checkOutput("async reset res", {22'd0, res0}, 0);
        checkOutput("async reset adder_a", {27'd0, adderA0}, 0);
        checkOutput("async reset flag_c", {31'd0, flagC0}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("held reset res_valid", {31'd0, resValid0}, 0);
        end
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'b00, 5'd1, 5'd1, 2);
        checkResult(10'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        acceptResult();

        sel = 1'b1;
        #1;
        applyStimulus(2'b10, 5'd3, 5'd4, 2);
        checkResult(10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        acceptResult();
        applyStimulus(2'b00, 5'd3, 5'd4, 2);
        checkResult(10'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        acceptResult();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-level controller for the shared 5-bit ripple adder/subtractor (adder with B XOR cin and carry-in; ports A, B, cin, Result, Cout).
- Accepts one operation at a time over a valid/ready command channel and drives the adder's operand and carry-in inputs.
- Sequences single-pass ADD/SUB/CMP and a 5-iteration shift-add unsigned MUL.
- Returns a 10-bit result and flags on a valid/ready result channel.

Parameters:
- MUL_EN, 1: 1 = MUL op supported; 0 = MUL op is illegal and reported via err.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 CMP
- cmd_a  in  5  operand A
- cmd_b  in  5  operand B
- adder_a  out  5  to adder A
- adder_b  out  5  to adder B (raw; adder inverts it when cin=1)
- adder_cin  out  1  to adder cin
- adder_result  in  5  from adder Result
- adder_cout  in  1  from adder Cout
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res  out  10  result
- flag_c  out  1  carry (SUB/CMP: 1 = no borrow)
- flag_z  out  1  zero
- flag_v  out  1  signed overflow (two's complement 5-bit)
- err  out  1  illegal op

Behaviour:
- Reset: rst_n low clears everything immediately, regardless of clock.
  - State returns to IDLE.
  - res, flags, err, res_valid and all adder_* outputs go to 0.
  - cmd_ready = 1 (it is decoded from state IDLE).
  - Any in-flight operation is discarded; no partial result is ever presented.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - cmd_ready = 1.
  - On the edge where cmd_valid && cmd_ready: latch op, A and B; go to EXEC, or to MUL if op=MUL and MUL_EN=1.
- EXEC (one cycle):
  - ADD: adder_a = A, adder_b = B, adder_cin = 0.
  - SUB/CMP: adder_a = A, adder_b = B, adder_cin = 1.
  - Capture adder_result and adder_cout at the end of the cycle; go to DONE.
  - MUL with MUL_EN=0: no adder use; res = 0, flags = 0, err = 1; go to DONE.
- MUL (exactly 5 cycles, iteration counter 0..4):
  - Registers: P (5-bit, cleared on accept), Q = B (multiplier), M = A.
  - Adder drive: adder_a = P, adder_b = Q[0] ? M : 0, adder_cin = 0.
  - End of each cycle: {P, Q} <= {adder_cout, adder_result, Q} >> 1, keeping the low 10 bits.
  - After iteration 4: res = {P, Q}; go to DONE.
- DONE:
  - res_valid = 1; res and flags stay stable until accepted.
  - On res_valid && res_ready: go to IDLE. cmd_ready returns one cycle later, so there is no same-cycle command overlap.
- Latency from the accepting edge to res_valid high: 2 edges for ADD/SUB/CMP/illegal, 6 edges for MUL.
- Adder outputs are 0 in IDLE and DONE.
- Result formatting:
  - ADD/SUB: res = {5'b0, sum}.
  - CMP: res = 0; flags come from the subtraction.
  - MUL: full 10-bit unsigned product.
- Flags:
  - flag_c = adder_cout for ADD/SUB/CMP; 0 for MUL.
  - flag_z = (sum == 0) for ADD/SUB/CMP; (product == 0) for MUL.
  - flag_v for ADD = (A4 == B4) && (S4 != A4).
  - flag_v for SUB/CMP = (A4 != B4) && (S4 != A4).
  - flag_v for MUL = 0.
  - err = 0 on every legal op.
- cmd_valid while busy: ignored (cmd_ready = 0); the operand inputs may change freely.
- res_ready while not res_valid: ignored.

Test Plan:
- ADD A=13 B=9 -> res=22 (0x016), flag_c=0, flag_z=0, flag_v=1; res_valid 2 edges after accept; adder_cin=0 during EXEC.
- SUB A=5 B=7 -> res=30 (11110b), flag_c=0, flag_v=0, flag_z=0; adder_cin=1 and adder_b=7 during EXEC.
- CMP A=18 B=18 -> res=0, flag_z=1, flag_c=1, flag_v=0. Then MUL A=31 B=31 -> res=961 (0x3C1) after 6 edges, flag_c=0; adder_b alternates M/0 per Q[0].
- Backpressure: hold res_ready=0 for 4 cycles after ADD 1+2 -> res=3 stable, cmd_ready=0 throughout. After the accept edge, cmd_ready=1 on the next cycle and the next command is taken.
- Reset mid-MUL: assert rst_n low during iteration 2 -> all outputs 0 and cmd_ready=1 at once, with no res_valid. After release, ADD 1+1 -> res=2.
- MUL_EN=0 build: MUL A=3 B=4 -> err=1, res=0 after 2 edges; a following ADD 3+4 -> res=7, err=0.
